writeback_queue: RTL and testbench
==================================

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 Parameter XLEN, default 64, data width of every result and write port.
REQ-002 Parameter DEPTH, default 4, number of queue entries, power of two and at least 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 alu_valid / alu_rd / alu_data  input  1 / 5 / XLEN  ALU result request.
REQ-006 mem_valid / mem_rd / mem_data  input  1 / 5 / XLEN  load-unit result request.
REQ-007 in_ready  output  1  high when the queue can accept both sources this cycle.
REQ-008 RegWrite / WriteRegister / WriteData  output  1 / 5 / XLEN  registered write port driving the register file.
REQ-009 RS1 / RS2  input  5 / 5  read addresses, used for forwarding lookup.
REQ-010 Fwd1Valid / Fwd1Data / Fwd2Valid / Fwd2Data  output  1 / XLEN / 1 / XLEN  forwarded pending values for RS1 / RS2.
REQ-011 pending  output  clog2(DEPTH)+1  number of occupied queue entries.
REQ-012 overflow  output  1  sticky error flag.

Function
REQ-013 in_ready SHALL be 1 when free entries >= 2, and 0 otherwise; it is combinational from registered state only.
REQ-014 Any valid request with rd == 0 SHALL be discarded and SHALL never occupy an entry.
REQ-015 When both requests are valid in the same cycle, the mem request SHALL be enqueued first (older) and the alu request second.
REQ-016 A valid nonzero-rd request arriving while in_ready == 0 SHALL be dropped.
REQ-017 A dropped request SHALL set overflow, which stays 1 until reset.
REQ-018 On each edge with the queue non-empty, the head SHALL pop into the write-port register: RegWrite=1 with its rd and data.
REQ-019 With the queue empty, RegWrite SHALL be 0; WriteRegister and WriteData SHALL hold their last values.
REQ-020 Latency SHALL be: a request enqueued at edge k drives RegWrite high during the cycle after edge k+1 when the queue was empty, so the register file commits it at edge k+2.
REQ-021 Throughput SHALL be one drain per cycle; push and pop in the same cycle SHALL both take effect, so pending = old + pushes - pop.
REQ-022 Pointers SHALL wrap modulo DEPTH; pending SHALL never exceed DEPTH.
REQ-023 FwdNValid SHALL be 1 when RSN != 0 and RSN matches any queue entry, or matches the write-port register while RegWrite == 1.
REQ-024 FwdNData SHALL come from the newest match: queue entries newest-first, then the write-port register.
REQ-025 When FwdNValid == 0, FwdNData SHALL be 0.
REQ-026 Forwarding SHALL NOT consider same-cycle inputs (alu_*, mem_*).
REQ-027 Multiple pending writes to the same rd SHALL all drain in order; none are merged.

Reset
REQ-028 Asserting reset SHALL, without waiting for clk, empty the queue and zero the pointers, pending, RegWrite, WriteRegister, WriteData and overflow.
REQ-029 Reset SHALL drive in_ready=1 and Fwd1Valid/Fwd2Valid=0.
REQ-030 Reset asserted mid-drain SHALL discard all pending entries; no write SHALL be emitted after reset deasserts until new requests arrive.

Structure
REQ-031 A shared package SHALL hold XLEN, REG_ADDR_W=5 and the entry typedef {rd[4:0], data[XLEN-1:0]}.
REQ-032 Storage SHALL be a sub-module wb_fifo: a circular buffer with 2-push/1-pop, occupancy count, and all entries exposed for the forwarding compare.
REQ-033 Forwarding priority logic and the write-port register SHALL live in writeback_queue.

Verification
REQ-034 Basic path: alu_valid=1, alu_rd=5, alu_data=0xAA at edge 0 -> RegWrite=1, WriteRegister=5, WriteData=0xAA after edge 1; RegWrite=0 after edge 2.
REQ-035 Ordering: mem(rd=3,0x11) and alu(rd=4,0x22) in the same cycle -> writes rd3 then rd4 on consecutive cycles; pending goes 2,1,0.
REQ-036 x0 discard: alu_rd=0, alu_data=0xFF -> pending stays 0, RegWrite never asserts, overflow stays 0.
REQ-037 Overflow: fill to DEPTH-1 entries, then push both sources -> in_ready=0, both requests dropped, overflow=1 and sticky; queued entries still drain intact.
REQ-038 Forwarding: queue rd7=0x1 then rd7=0x2, RS1=7, RS2=0 -> Fwd1Valid=1 with Fwd1Data=0x2, Fwd2Valid=0; after the last rd7 write retires, Fwd1Valid=0.
REQ-039 Reset mid-operation: 3 entries pending, assert reset between edges -> RegWrite, pending and overflow go to 0 immediately; no writes follow deassertion.

Source files
------------

// File: rtl/writeback_queue_pkg.sv
// Shared widths and queue-entry layout for the writeback queue and its storage.
package writeback_queue_pkg;

  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } entry_t;

endpackage

// File: rtl/writeback_queue_fifo.sv
// Circular buffer for pending register writes: up to two pushes and one pop per cycle,
// with every slot presented oldest-first so the forwarding compare can scan by age.
module wb_fifo
  import writeback_queue_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              i_push_cnt,
  input  logic [REG_ADDR_W-1:0]   i_rd0,
  input  logic [XLEN-1:0]         i_data0,
  input  logic [REG_ADDR_W-1:0]   i_rd1,
  input  logic [XLEN-1:0]         i_data1,
  input  logic                    i_pop,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_vld  [DEPTH],
  output logic [REG_ADDR_W-1:0]   o_rd   [DEPTH],
  output logic [XLEN-1:0]         o_data [DEPTH]
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic [REG_ADDR_W-1:0] r_rd   [DEPTH];
  logic [XLEN-1:0]       r_data [DEPTH];
  logic [PW-1:0]         w_wptr1;

  assign w_wptr1 = r_wptr + PW'(1);
  assign o_count = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= r_wptr + PW'(i_push_cnt);
      r_rptr  <= r_rptr + PW'(i_pop);
      r_count <= r_count + CW'(i_push_cnt) - CW'(i_pop);
    end
  end

  // Slot contents need no reset: the occupancy count alone decides what is live.
  always_ff @(posedge clk) begin
    if (i_push_cnt != 2'd0) begin
      r_rd[r_wptr]   <= i_rd0;
      r_data[r_wptr] <= i_data0;
    end
    if (i_push_cnt == 2'd2) begin
      r_rd[w_wptr1]   <= i_rd1;
      r_data[w_wptr1] <= i_data1;
    end
  end

  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      o_vld[j]  = CW'(j) < r_count;
      o_rd[j]   = r_rd[r_rptr + PW'(j)];
      o_data[j] = r_data[r_rptr + PW'(j)];
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// Merges ALU and load results into one ordered stream of register-file writes,
// and forwards still-pending values to the read ports.
module writeback_queue
  import writeback_queue_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alu_valid,
  input  logic [REG_ADDR_W-1:0]  alu_rd,
  input  logic [XLEN-1:0]        alu_data,
  input  logic                   mem_valid,
  input  logic [REG_ADDR_W-1:0]  mem_rd,
  input  logic [XLEN-1:0]        mem_data,
  output logic                   in_ready,
  output logic                   RegWrite,
  output logic [REG_ADDR_W-1:0]  WriteRegister,
  output logic [XLEN-1:0]        WriteData,
  input  logic [REG_ADDR_W-1:0]  RS1,
  input  logic [REG_ADDR_W-1:0]  RS2,
  output logic                   Fwd1Valid,
  output logic [XLEN-1:0]        Fwd1Data,
  output logic                   Fwd2Valid,
  output logic [XLEN-1:0]        Fwd2Data,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   overflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic                  w_memReq, w_aluReq, w_memTake, w_aluTake, w_drop, w_pop;
  logic [1:0]            w_pushCnt;
  logic [REG_ADDR_W-1:0] w_rd0;
  logic [XLEN-1:0]       w_data0;
  logic [CW-1:0]         w_count;
  logic                  w_vld  [DEPTH];
  logic [REG_ADDR_W-1:0] w_rd   [DEPTH];
  logic [XLEN-1:0]       w_data [DEPTH];

  logic                  r_regWrite;
  logic [REG_ADDR_W-1:0] r_writeReg;
  logic [XLEN-1:0]       r_writeData;
  logic                  r_overflow;

  // Writes to x0 never enter the queue; the load result is always the older slot.
  assign w_memReq  = mem_valid && (mem_rd != '0);
  assign w_aluReq  = alu_valid && (alu_rd != '0);
  assign in_ready  = (CW'(DEPTH) - w_count) >= CW'(2);
  assign w_memTake = w_memReq && in_ready;
  assign w_aluTake = w_aluReq && in_ready;
  assign w_drop    = (w_memReq || w_aluReq) && !in_ready;
  assign w_pushCnt = {1'b0, w_memTake} + {1'b0, w_aluTake};
  assign w_rd0     = w_memTake ? mem_rd   : alu_rd;
  assign w_data0   = w_memTake ? mem_data : alu_data;
  assign w_pop     = (w_count != '0);

  wb_fifo #(.XLEN(XLEN), .DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (reset),
    .i_push_cnt (w_pushCnt),
    .i_rd0      (w_rd0),
    .i_data0    (w_data0),
    .i_rd1      (alu_rd),
    .i_data1    (alu_data),
    .i_pop      (w_pop),
    .o_count    (w_count),
    .o_vld      (w_vld),
    .o_rd       (w_rd),
    .o_data     (w_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_regWrite  <= 1'b0;
      r_writeReg  <= '0;
      r_writeData <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_regWrite <= w_pop;
      r_overflow <= r_overflow | w_drop;
      if (w_pop) begin
        r_writeReg  <= w_rd[0];
        r_writeData <= w_data[0];
      end
    end
  end

  // Later (newer) matches overwrite earlier ones, so the youngest pending write wins.
  function automatic logic [XLEN:0] fwdLookup(input logic [REG_ADDR_W-1:0] rs);
    logic [XLEN:0] hit;
    hit = '0;
    if (rs != '0) begin
      if (r_regWrite && (r_writeReg == rs)) hit = {1'b1, r_writeData};
      for (int j = 0; j < DEPTH; j++)
        if (w_vld[j] && (w_rd[j] == rs)) hit = {1'b1, w_data[j]};
    end
    return hit;
  endfunction

  always_comb begin
    {Fwd1Valid, Fwd1Data} = fwdLookup(RS1);
    {Fwd2Valid, Fwd2Data} = fwdLookup(RS2);
  end

  assign RegWrite      = r_regWrite;
  assign WriteRegister = r_writeReg;
  assign WriteData     = r_writeData;
  assign pending       = w_count;
  assign overflow      = r_overflow;

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench: accepted requests are queued as expected writes and a negedge
// monitor compares each register-file write against them in order.
module tb_writeback_queue;
  import writeback_queue_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, mem_valid;
  logic [4:0]  alu_rd, mem_rd, RS1, RS2;
  logic [63:0] alu_data, mem_data;
  logic        in_ready, RegWrite, Fwd1Valid, Fwd2Valid, overflow;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData, Fwd1Data, Fwd2Data;
  logic [2:0]  pending;

  entry_t expQ[$];
  int errorCount = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  writeback_queue #(.XLEN(64), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
    .in_ready(in_ready),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .RS1(RS1), .RS2(RS2),
    .Fwd1Valid(Fwd1Valid), .Fwd1Data(Fwd1Data),
    .Fwd2Valid(Fwd2Valid), .Fwd2Data(Fwd2Data),
    .pending(pending), .overflow(overflow)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] want);
    checkCount++;
    if (act !== want) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  // Called at posedge+1; holds the request across exactly one rising edge.
  task automatic applyStimulus(input logic mv, input logic [4:0] mrd, input logic [63:0] md,
                               input logic av, input logic [4:0] ard, input logic [63:0] ad,
                               input logic expAccept);
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    if (expAccept) begin
      if (mv && mrd != 5'd0) expQ.push_back('{rd: mrd, data: md});
      if (av && ard != 5'd0) expQ.push_back('{rd: ard, data: ad});
    end
    @(posedge clk); #1;
    mem_valid = 1'b0;
    alu_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    entry_t e;
    if (RegWrite !== 1'b0) begin
      checkCount++;
      if (expQ.size() == 0) begin
        errorCount++;
        $display("[TB] FAIL write: got RegWrite=%b rd=%0d data=0x%0h, expected no write",
                 RegWrite, WriteRegister, WriteData);
      end else begin
        e = expQ.pop_front();
        if (RegWrite !== 1'b1 || WriteRegister !== e.rd || WriteData !== e.data) begin
          errorCount++;
          $display("[TB] FAIL write: got rd=%0d data=0x%0h, expected rd=%0d data=0x%0h",
                   WriteRegister, WriteData, e.rd, e.data);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    RS1 = '0; RS2 = '0;
    #2;
    checkOutput("reset pending",   64'(pending),   64'd0);
    checkOutput("reset in_ready",  64'(in_ready),  64'd1);
    checkOutput("reset RegWrite",  64'(RegWrite),  64'd0);
    checkOutput("reset overflow",  64'(overflow),  64'd0);
    checkOutput("reset Fwd1Valid", 64'(Fwd1Valid), 64'd0);
    checkOutput("reset Fwd2Valid", 64'(Fwd2Valid), 64'd0);
    #10 reset = 1'b0;
    @(posedge clk); #1;

    $display("[TB] basic path");
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b1, 5'd5, 64'hAA, 1'b1);
    @(negedge clk);
    checkOutput("basic pending k", 64'(pending),  64'd1);
    checkOutput("basic RegWrite k", 64'(RegWrite), 64'd0);
    @(negedge clk);
    checkOutput("basic RegWrite k+1", 64'(RegWrite), 64'd1);
    checkOutput("basic WriteData", WriteData, 64'hAA);
    checkOutput("basic pending k+1", 64'(pending), 64'd0);
    @(negedge clk);
    checkOutput("basic RegWrite k+2", 64'(RegWrite), 64'd0);
    checkOutput("basic WriteRegister hold", 64'(WriteRegister), 64'd5);
    @(posedge clk); #1;

    $display("[TB] ordering");
    applyStimulus(1'b1, 5'd3, 64'h11, 1'b1, 5'd4, 64'h22, 1'b1);
    @(negedge clk);
    checkOutput("order pending 2", 64'(pending), 64'd2);
    @(negedge clk);
    checkOutput("order pending 1", 64'(pending), 64'd1);
    checkOutput("order first rd", 64'(WriteRegister), 64'd3);
    @(negedge clk);
    checkOutput("order pending 0", 64'(pending), 64'd0);
    checkOutput("order second rd", 64'(WriteRegister), 64'd4);
    @(negedge clk);
    checkOutput("order idle", 64'(RegWrite), 64'd0);
    @(posedge clk); #1;

    $display("[TB] x0 discard");
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b1, 5'd0, 64'hFF, 1'b1);
    @(negedge clk);
    checkOutput("x0 pending", 64'(pending), 64'd0);
    @(negedge clk);
    checkOutput("x0 RegWrite", 64'(RegWrite), 64'd0);
    checkOutput("x0 overflow", 64'(overflow), 64'd0);
    @(posedge clk); #1;

    $display("[TB] forwarding");
    RS1 = 5'd7; RS2 = 5'd0;
    applyStimulus(1'b1, 5'd7, 64'h1, 1'b1, 5'd7, 64'h2, 1'b1);
    @(negedge clk);
    checkOutput("fwd1 valid q2", 64'(Fwd1Valid), 64'd1);
    checkOutput("fwd1 data q2",  Fwd1Data,       64'h2);
    checkOutput("fwd2 valid x0", 64'(Fwd2Valid), 64'd0);
    checkOutput("fwd2 data x0",  Fwd2Data,       64'h0);
    @(negedge clk);
    checkOutput("fwd1 data newest", Fwd1Data, 64'h2);
    @(negedge clk);
    checkOutput("fwd1 valid port", 64'(Fwd1Valid), 64'd1);
    checkOutput("fwd1 data port",  Fwd1Data,       64'h2);
    @(negedge clk);
    checkOutput("fwd1 valid retired", 64'(Fwd1Valid), 64'd0);
    checkOutput("fwd1 data retired",  Fwd1Data,       64'h0);
    @(posedge clk); #1;

    $display("[TB] overflow");
    applyStimulus(1'b1, 5'd10, 64'hA0, 1'b1, 5'd11, 64'hB0, 1'b1);
    applyStimulus(1'b1, 5'd12, 64'hC0, 1'b1, 5'd13, 64'hD0, 1'b1);
    checkOutput("ovf pending full-1", 64'(pending),  64'd3);
    checkOutput("ovf in_ready",       64'(in_ready), 64'd0);
    applyStimulus(1'b1, 5'd14, 64'hE0, 1'b1, 5'd15, 64'hF0, 1'b0);
    @(negedge clk);
    checkOutput("ovf flag", 64'(overflow), 64'd1);
    checkOutput("ovf pending after drop", 64'(pending), 64'd2);
    repeat (3) @(negedge clk);
    checkOutput("ovf drained",  64'(pending),  64'd0);
    checkOutput("ovf sticky",   64'(overflow), 64'd1);
    checkOutput("ovf in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    $display("[TB] reset mid-drain");
    RS1 = 5'd23; RS2 = 5'd20;
    applyStimulus(1'b1, 5'd20, 64'h200, 1'b1, 5'd21, 64'h210, 1'b1);
    applyStimulus(1'b1, 5'd22, 64'h220, 1'b1, 5'd23, 64'h230, 1'b1);
    checkOutput("mid pending",    64'(pending),   64'd3);
    checkOutput("mid fwd1 valid", 64'(Fwd1Valid), 64'd1);
    checkOutput("mid fwd1 data",  Fwd1Data,       64'h230);
    checkOutput("mid fwd2 valid", 64'(Fwd2Valid), 64'd1);
    checkOutput("mid fwd2 data",  Fwd2Data,       64'h200);
    #2;
    reset = 1'b1;
    expQ.delete();
    #1;
    checkOutput("async RegWrite",  64'(RegWrite),  64'd0);
    checkOutput("async pending",   64'(pending),   64'd0);
    checkOutput("async overflow",  64'(overflow),  64'd0);
    checkOutput("async in_ready",  64'(in_ready),  64'd1);
    checkOutput("async Fwd1Valid", 64'(Fwd1Valid), 64'd0);
    #3 reset = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("post-reset pending",  64'(pending),  64'd0);
    checkOutput("post-reset RegWrite", 64'(RegWrite), 64'd0);

    checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
